// File: rtl/mac_pkg.sv
// Shared definitions for the MAC front end: default group geometry, the
// scheduler state encoding and the zero-product rule.
package mac_pkg;

  localparam int GROUP = 9;
  localparam int PP_W  = 4;
  localparam int EXP_W = 6;
  localparam int QF_W  = 5;
  localparam int IDX_W = 4;

  typedef enum logic {
    COLLECT = 1'b0,
    ISSUE   = 1'b1
  } state_e;

  // A product is zero when its magnitude field is empty; the sign bit is ignored.
  function automatic logic pp_is_zero(input logic [PP_W-1:0] pp);
    return (pp[PP_W-2:0] == {(PP_W-1){1'b0}});
  endfunction

endpackage

// File: rtl/exp_max_tracker.sv
// Running unsigned maximum of the exponents in one group; zero products
// contribute an exponent of 0 so they can never raise the maximum.
module exp_max_tracker #(
  parameter int EXP_W = mac_pkg::EXP_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_update,
  input  logic             i_zero,
  input  logic [EXP_W-1:0] i_exp,
  output logic [EXP_W-1:0] o_max
);

  logic [EXP_W-1:0] w_cand;
  logic [EXP_W-1:0] r_max;

  // Candidate exponent after zero-product suppression.
  always_comb begin
    w_cand = {EXP_W{1'b0}};
    if (i_zero) begin
      w_cand = {EXP_W{1'b0}};
    end else begin
      w_cand = i_exp;
    end
  end

  // Load restarts the maximum for a new group; update only ever raises it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_max <= {EXP_W{1'b0}};
    end else if (i_load) begin
      r_max <= w_cand;
    end else if (i_update && (w_cand > r_max)) begin
      r_max <= w_cand;
    end else begin
      r_max <= r_max;
    end
  end

  assign o_max = r_max;

endmodule

// File: rtl/align_group_scheduler.sv
// Collects a group of partial products while tracking their maximum exponent,
// then replays the group to the alignment stage with the common max attached.
module align_group_scheduler
  import mac_pkg::*;
#(
  parameter int GROUP = mac_pkg::GROUP,
  parameter int PP_W  = mac_pkg::PP_W,
  parameter int EXP_W = mac_pkg::EXP_W,
  parameter int QF_W  = mac_pkg::QF_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [PP_W-1:0]  i_denorm_pp,
  input  logic [EXP_W-1:0] i_exp,
  input  logic [QF_W-1:0]  i_Q_frac,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [PP_W-1:0]  o_denorm_pp,
  output logic [EXP_W-1:0] o_exp,
  output logic [EXP_W-1:0] o_max_exp,
  output logic [QF_W-1:0]  o_Q_frac,
  output logic [3:0]       o_idx,
  output logic             o_last
);

  localparam logic [3:0] LAST_IDX = 4'(GROUP - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [3:0]       r_wr_cnt;
  logic [3:0]       r_rd_cnt;
  logic [QF_W-1:0]  r_qf;
  logic [PP_W-1:0]  r_buf_pp  [GROUP];
  logic [EXP_W-1:0] r_buf_exp [GROUP];
  logic             w_accept;
  logic             w_issue;
  logic             w_first;
  logic             w_wr_last;
  logic             w_rd_last;
  logic [EXP_W-1:0] w_max;

  assign w_first   = (r_wr_cnt == 4'd0);
  assign w_wr_last = (r_wr_cnt == LAST_IDX);
  assign w_rd_last = (r_rd_cnt == LAST_IDX);

  // Handshake flags depend only on the state register, never on i_valid/i_ready paths back out.
  always_comb begin
    o_ready  = 1'b1;
    o_valid  = 1'b0;
    w_accept = 1'b0;
    w_issue  = 1'b0;
    case (r_state)
      COLLECT: begin
        o_ready  = 1'b1;
        o_valid  = 1'b0;
        w_accept = i_valid;
      end
      ISSUE: begin
        o_ready = 1'b0;
        o_valid = 1'b1;
        w_issue = i_ready;
      end
      default: begin
        o_ready = 1'b1;
        o_valid = 1'b0;
      end
    endcase
  end

  // Next-state selection.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      COLLECT: begin
        if (w_accept && w_wr_last) begin
          w_state_nxt = ISSUE;
        end else begin
          w_state_nxt = COLLECT;
        end
      end
      ISSUE: begin
        if (w_issue && w_rd_last) begin
          w_state_nxt = COLLECT;
        end else begin
          w_state_nxt = ISSUE;
        end
      end
      default: w_state_nxt = COLLECT;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Write and read pointers wrap at the end of each group.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_cnt <= 4'd0;
      r_rd_cnt <= 4'd0;
    end else begin
      if (w_accept) begin
        r_wr_cnt <= w_wr_last ? 4'd0 : (r_wr_cnt + 4'd1);
      end
      if (w_issue) begin
        r_rd_cnt <= w_rd_last ? 4'd0 : (r_rd_cnt + 4'd1);
      end
    end
  end

  // Group buffer and the Q_frac latched from the first beat.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_qf <= {QF_W{1'b0}};
      for (int i = 0; i < GROUP; i++) begin
        r_buf_pp[i]  <= {PP_W{1'b0}};
        r_buf_exp[i] <= {EXP_W{1'b0}};
      end
    end else if (w_accept) begin
      r_buf_pp[r_wr_cnt]  <= i_denorm_pp;
      r_buf_exp[r_wr_cnt] <= i_exp;
      if (w_first) begin
        r_qf <= i_Q_frac;
      end
    end
  end

  exp_max_tracker #(
    .EXP_W (EXP_W)
  ) u_max (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_load   (w_accept && w_first),
    .i_update (w_accept && !w_first),
    .i_zero   (pp_is_zero(i_denorm_pp)),
    .i_exp    (i_exp),
    .o_max    (w_max)
  );

  assign o_denorm_pp = r_buf_pp[r_rd_cnt];
  assign o_exp       = r_buf_exp[r_rd_cnt];
  assign o_max_exp   = w_max;
  assign o_Q_frac    = r_qf;
  assign o_idx       = r_rd_cnt;
  assign o_last      = (r_state == ISSUE) && w_rd_last;

endmodule

// File: tb/tb_align_group_scheduler.sv
// Randomized directed bench for align_group_scheduler with a group-level
// reference model (expected max computed directly from the stored group).
module tb_align_group_scheduler;

  localparam int G = 9;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_valid;
  logic       o_ready;
  logic [3:0] i_denorm_pp;
  logic [5:0] i_exp;
  logic [4:0] i_Q_frac;
  logic       o_valid;
  logic       i_ready;
  logic [3:0] o_denorm_pp;
  logic [5:0] o_exp;
  logic [5:0] o_max_exp;
  logic [4:0] o_Q_frac;
  logic [3:0] o_idx;
  logic       o_last;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] g_pp  [G];
  logic [5:0] g_exp [G];
  logic [4:0] g_qf;

  align_group_scheduler dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_denorm_pp (i_denorm_pp),
    .i_exp       (i_exp),
    .i_Q_frac    (i_Q_frac),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_denorm_pp (o_denorm_pp),
    .o_exp       (o_exp),
    .o_max_exp   (o_max_exp),
    .o_Q_frac    (o_Q_frac),
    .o_idx       (o_idx),
    .o_last      (o_last)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Reference: maximum exponent over nonzero-magnitude products, 0 if none.
  function automatic logic [5:0] ref_max();
    logic [5:0] m;
    m = 6'd0;
    for (int i = 0; i < G; i++) begin
      if (g_pp[i][2:0] != 3'd0 && g_exp[i] > m) m = g_exp[i];
    end
    return m;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 32'(o_ready), 32'd1);
    check({tag, "_valid"}, 32'(o_valid), 32'd0);
    check({tag, "_last"},  32'(o_last),  32'd0);
    check({tag, "_idx"},   32'(o_idx),   32'd0);
    check({tag, "_pp"},    32'(o_denorm_pp), 32'd0);
    check({tag, "_exp"},   32'(o_exp),   32'd0);
    check({tag, "_max"},   32'(o_max_exp), 32'd0);
    check({tag, "_qf"},    32'(o_Q_frac), 32'd0);
  endtask

  task automatic async_reset(input string tag);
    i_valid  = 1'b0;
    i_ready  = 1'b0;
    i_rst_n  = 1'b0;
    #1;
    check_reset_vals(tag);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  task automatic gen_random(input int max_e, input bit nonzero);
    for (int i = 0; i < G; i++) begin
      g_pp[i]  = 4'($urandom);
      if (nonzero) g_pp[i][2:0] = 3'($urandom_range(7, 1));
      g_exp[i] = 6'($urandom_range(max_e, 0));
    end
    g_qf = 5'($urandom);
  endtask

  task automatic collect(input int nbeats, input int gap_before, input int gap_len);
    for (int b = 0; b < nbeats; b++) begin
      if (b == gap_before) begin
        for (int k = 0; k < gap_len; k++) begin
          i_valid     = 1'b0;
          i_denorm_pp = 4'($urandom);
          i_exp       = 6'($urandom);
          check("gap_ready", 32'(o_ready), 32'd1);
          step();
        end
      end
      i_valid     = 1'b1;
      i_denorm_pp = g_pp[b];
      i_exp       = g_exp[b];
      i_Q_frac    = (b == 0) ? g_qf : 5'($urandom);
      check("col_ready", 32'(o_ready), 32'd1);
      check("col_valid", 32'(o_valid), 32'd0);
      step();
    end
    i_valid     = 1'b0;
    i_denorm_pp = 4'd0;
    i_exp       = 6'd0;
  endtask

  // mode 0: always ready, 1: random ready, 2: ready pattern 1,0,0,1.
  task automatic issue(input int nbeats, input int mode, input logic [5:0] exp_max);
    int k;
    int cyc;
    k   = 0;
    cyc = 0;
    while (k < nbeats && cyc < 400) begin
      check("iss_valid", 32'(o_valid), 32'd1);
      check("iss_ready", 32'(o_ready), 32'd0);
      check("iss_pp",    32'(o_denorm_pp), 32'(g_pp[k]));
      check("iss_exp",   32'(o_exp),   32'(g_exp[k]));
      check("iss_max",   32'(o_max_exp), 32'(exp_max));
      check("iss_qf",    32'(o_Q_frac), 32'(g_qf));
      check("iss_idx",   32'(o_idx),   32'(k));
      check("iss_last",  32'(o_last),  32'(k == G - 1));
      case (mode)
        0:       i_ready = 1'b1;
        1:       i_ready = 1'($urandom);
        default: i_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      endcase
      step();
      if (i_ready) k++;
      cyc++;
    end
    check("iss_count", 32'(k), 32'(nbeats));
    i_ready = 1'b0;
  endtask

  task automatic full_group(input int mode, input int gap_before, input int gap_len,
                            input logic [5:0] exp_max);
    collect(G, gap_before, gap_len);
    issue(G, mode, exp_max);
    check("post_valid", 32'(o_valid), 32'd0);
    check("post_ready", 32'(o_ready), 32'd1);
  endtask

  initial begin
    int basic_e [G];
    basic_e = '{3, 7, 1, 12, 5, 0, 9, 2, 4};
    i_rst_n     = 1'b0;
    i_valid     = 1'b0;
    i_ready     = 1'b0;
    i_denorm_pp = 4'd0;
    i_exp       = 6'd0;
    i_Q_frac    = 5'd0;
    repeat (2) @(posedge i_clk);
    #1;
    check_reset_vals("rst");
    i_rst_n = 1'b1;
    step();

    // Basic group.
    gen_random(63, 1'b1);
    for (int i = 0; i < G; i++) g_exp[i] = 6'(basic_e[i]);
    g_qf = 5'h0B;
    full_group(0, -1, 0, 6'd12);

    // Input gap of 3 cycles between beats 2 and 3, same data.
    full_group(0, 3, 3, 6'd12);

    // Zero product with exp 63 excluded.
    gen_random(19, 1'b1);
    g_exp[$urandom_range(8, 5)] = 6'd20;
    g_pp[4]  = 4'b1000;
    g_exp[4] = 6'd63;
    full_group(1, -1, 0, 6'd20);

    // All-zero group.
    gen_random(63, 1'b0);
    for (int i = 0; i < G; i++) g_pp[i][2:0] = 3'd0;
    g_exp[0] = 6'd50;
    full_group(0, -1, 0, 6'd0);

    // Back-pressure pattern.
    gen_random(63, 1'b1);
    full_group(2, -1, 0, ref_max());

    // Reset after 5 accepted beats, then a lower-max group.
    gen_random(63, 1'b1);
    g_exp[1] = 6'd63;
    collect(5, -1, 0);
    async_reset("rst_col");
    gen_random(15, 1'b1);
    full_group(0, -1, 0, ref_max());

    // Reset after 4 issued beats, then a lower-max group.
    gen_random(63, 1'b1);
    g_exp[2] = 6'd60;
    collect(G, -1, 0);
    issue(4, 0, ref_max());
    async_reset("rst_iss");
    gen_random(15, 1'b1);
    full_group(1, -1, 0, ref_max());

    // Back-to-back: group A max 30 then group B max 5.
    gen_random(29, 1'b1);
    g_exp[6] = 6'd30;
    full_group(0, -1, 0, 6'd30);
    gen_random(4, 1'b1);
    g_exp[0] = 6'd5;
    full_group(0, -1, 0, 6'd5);

    // Random groups with random gaps and back-pressure.
    for (int n = 0; n < 6; n++) begin
      gen_random(63, 1'(n % 2));
      full_group(1, $urandom_range(8, 0), $urandom_range(3, 0), ref_max());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
